// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the RISC CPU control unit: FSM state encoding,
// memory command codes, writeback-select codes and instruction opcode/op
// constants. Imported by instr_dec and cpu_controller.
package cpu_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RST,
        S_IF1,
        S_IF2,
        S_UPC,
        S_DEC,
        S_WIMM,
        S_GETA,
        S_GETB,
        S_EXEC,
        S_WC,
        S_ADDR,
        S_LDA,
        S_MRD,
        S_MWB,
        S_GETD,
        S_PASS,
        S_MWR,
        S_HALT
    } state_t;

    // Memory command codes
    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    // Writeback select codes
    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    // Opcodes (ir[15:13])
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    // Op field (ir[12:11])
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MEM     = 2'b00;

endpackage

// File: rtl/instr_dec.sv
// instr_dec
// Purely combinational field extraction from the 16-bit instruction register.
// Ports:
//   i_ir       in  16  instruction register
//   o_opcode   out 3   ir[15:13]
//   o_op       out 2   ir[12:11]
//   o_rn       out 3   ir[10:8]
//   o_rd       out 3   ir[7:5]
//   o_sh       out 2   ir[4:3]
//   o_rm       out 3   ir[2:0]
//   o_sximm5   out 16  ir[4:0] sign-extended
//   o_sximm8   out 16  ir[7:0] sign-extended
module instr_dec
    import cpu_ctrl_pkg::*;
(
    input  logic [15:0] i_ir,
    output logic [2:0]  o_opcode,
    output logic [1:0]  o_op,
    output logic [2:0]  o_rn,
    output logic [2:0]  o_rd,
    output logic [1:0]  o_sh,
    output logic [2:0]  o_rm,
    output logic [15:0] o_sximm5,
    output logic [15:0] o_sximm8
);

    assign o_opcode = i_ir[15:13];
    assign o_op     = i_ir[12:11];
    assign o_rn     = i_ir[10:8];
    assign o_rd     = i_ir[7:5];
    assign o_sh     = i_ir[4:3];
    assign o_rm     = i_ir[2:0];
    assign o_sximm5 = {{11{i_ir[4]}}, i_ir[4:0]};
    assign o_sximm8 = {{8{i_ir[7]}}, i_ir[7:0]};

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller
// Moore-FSM control unit for the simple RISC CPU. Fetches via the PC,
// decodes the instruction register and sequences every datapath control.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   ir[15:0]                      instruction register
//   status[2:0]                   {Z,N,V}; not consumed yet
//   readnum, writenum, write      register-file controls
//   vsel[1:0]                     writeback select (C/PC/sximm8/mdata)
//   loada, loadb, loadc, loads    pipeline/status register enables
//   asel, bsel, shift, ALUop      operand/shifter/ALU controls
//   sximm8, sximm5                sign-extended immediates
//   load_ir, load_pc, reset_pc    IR/PC controls
//   load_addr, addr_sel           data-address register, address mux (1=PC)
//   mem_cmd[1:0]                  NONE/READ/WRITE
//   halt                          high in the halt state
module cpu_controller
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic [2:0]  status,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic        load_ir,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        load_addr,
    output logic        addr_sel,
    output logic [1:0]  mem_cmd,
    output logic        halt
);

    state_t     r_state;
    state_t     w_next_state;

    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [1:0] w_sh;
    logic [2:0] w_rm;

    // Status flags are reserved for future branch instructions.
    logic       w_unused_status;
    assign w_unused_status = ^status;

    instr_dec u_dec (
        .i_ir     (ir),
        .o_opcode (w_opcode),
        .o_op     (w_op),
        .o_rn     (w_rn),
        .o_rd     (w_rd),
        .o_sh     (w_sh),
        .o_rm     (w_rm),
        .o_sximm5 (sximm5),
        .o_sximm8 (sximm8)
    );

    logic w_is_mem;
    logic w_is_ldr;
    logic w_is_cmp;
    logic w_zero_a;

    // Only LDR/STR reach the memory path, so opcode alone identifies them.
    assign w_is_mem = (w_opcode == OPC_LDR) || (w_opcode == OPC_STR);
    assign w_is_ldr = (w_opcode == OPC_LDR);
    assign w_is_cmp = (w_opcode == OPC_ALU) && (w_op == OP_CMP);
    // MOV reg and MVN use only the B operand, so A is forced to zero.
    assign w_zero_a = ((w_opcode == OPC_MOV) && (w_op == OP_MOV_REG)) ||
                      ((w_opcode == OPC_ALU) && (w_op == OP_MVN));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        readnum      = 3'd0;
        writenum     = 3'd0;
        write        = 1'b0;
        vsel         = VSEL_C;
        loada        = 1'b0;
        loadb        = 1'b0;
        loadc        = 1'b0;
        loads        = 1'b0;
        asel         = 1'b0;
        bsel         = 1'b0;
        shift        = 2'b00;
        ALUop        = 2'b00;
        load_ir      = 1'b0;
        load_pc      = 1'b0;
        reset_pc     = 1'b0;
        load_addr    = 1'b0;
        addr_sel     = 1'b0;
        mem_cmd      = MEM_NONE;
        halt         = 1'b0;

        case (r_state)
            S_RST: begin
                reset_pc     = 1'b1;
                load_pc      = 1'b1;
                w_next_state = S_IF1;
            end
            S_IF1: begin
                addr_sel     = 1'b1;
                mem_cmd      = MEM_READ;
                w_next_state = S_IF2;
            end
            S_IF2: begin
                addr_sel     = 1'b1;
                mem_cmd      = MEM_READ;
                load_ir      = 1'b1;
                w_next_state = S_UPC;
            end
            S_UPC: begin
                load_pc      = 1'b1;
                w_next_state = S_DEC;
            end
            S_DEC: begin
                if (w_opcode == OPC_HALT) begin
                    w_next_state = S_HALT;
                end else begin
                    case ({w_opcode, w_op})
                        {OPC_MOV, OP_MOV_IMM}:   w_next_state = S_WIMM;
                        {OPC_MOV, OP_MOV_REG},
                        {OPC_ALU, OP_MVN}:       w_next_state = S_GETB;
                        {OPC_ALU, OP_ADD},
                        {OPC_ALU, OP_CMP},
                        {OPC_ALU, OP_AND},
                        {OPC_LDR, OP_MEM},
                        {OPC_STR, OP_MEM}:       w_next_state = S_GETA;
                        default:                 w_next_state = S_IF1;
                    endcase
                end
            end
            S_WIMM: begin
                vsel         = VSEL_IMM8;
                writenum     = w_rn;
                write        = 1'b1;
                w_next_state = S_IF1;
            end
            S_GETA: begin
                readnum      = w_rn;
                loada        = 1'b1;
                w_next_state = w_is_mem ? S_ADDR : S_GETB;
            end
            S_GETB: begin
                readnum      = w_rm;
                loadb        = 1'b1;
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                shift = w_sh;
                ALUop = w_op;
                asel  = w_zero_a;
                if (w_is_cmp) begin
                    loads        = 1'b1;
                    w_next_state = S_IF1;
                end else begin
                    loadc        = 1'b1;
                    w_next_state = S_WC;
                end
            end
            S_WC: begin
                vsel         = VSEL_C;
                writenum     = w_rd;
                write        = 1'b1;
                w_next_state = S_IF1;
            end
            S_ADDR: begin
                // Effective address = Rn + sximm5
                bsel         = 1'b1;
                loadc        = 1'b1;
                w_next_state = S_LDA;
            end
            S_LDA: begin
                load_addr    = 1'b1;
                w_next_state = w_is_ldr ? S_MRD : S_GETD;
            end
            S_MRD: begin
                mem_cmd      = MEM_READ;
                w_next_state = S_MWB;
            end
            S_MWB: begin
                // Read is held so mdata stays valid during the writeback.
                mem_cmd      = MEM_READ;
                vsel         = VSEL_MDATA;
                writenum     = w_rd;
                write        = 1'b1;
                w_next_state = S_IF1;
            end
            S_GETD: begin
                readnum      = w_rd;
                loadb        = 1'b1;
                w_next_state = S_PASS;
            end
            S_PASS: begin
                // 0 + Rd passes store data into C, which drives the write bus.
                asel         = 1'b1;
                loadc        = 1'b1;
                w_next_state = S_MWR;
            end
            S_MWR: begin
                mem_cmd      = MEM_WRITE;
                w_next_state = S_IF1;
            end
            S_HALT: begin
                halt         = 1'b1;
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_RST;
            end
        endcase
    end

endmodule
